// File: rtl/spi_slave_ctrl_if.sv
// rtl/spi_slave_ctrl_if.sv - SPI pin and RAM-side signal bundle for spi_slave_ctrl
interface spi_slave_ctrl_if #(
  parameter int ADDR_SIZE = 8
) ();
  logic                 SS_n;
  logic                 MOSI;
  logic                 MISO;
  logic [ADDR_SIZE+1:0] rx_data;
  logic                 rx_valid;
  logic [ADDR_SIZE-1:0] tx_data;
  logic                 tx_valid;

  modport slave (
    input  SS_n, MOSI, tx_data, tx_valid,
    output MISO, rx_data, rx_valid
  );

  modport master (
    output SS_n, MOSI, tx_data, tx_valid,
    input  MISO, rx_data, rx_valid
  );
endinterface

// File: rtl/spi_slave_ctrl.sv
// rtl/spi_slave_ctrl.sv - SPI mode-0 slave front end sequencing the single-port RAM
// Optional SPI_CMD_CHECK_EN: frame command vs state check with sticky cmd_err.
module spi_slave_ctrl #(
  parameter int ADDR_SIZE = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  spi_slave_ctrl_if.slave  bus,
  output logic             cmd_err
);

  localparam int FRAME_W = ADDR_SIZE + 2;
  localparam int BCNT_W  = $clog2(FRAME_W + 1);
  localparam int TCNT_W  = $clog2(ADDR_SIZE + 1);
  localparam logic [BCNT_W-1:0] BCNT_FULL = BCNT_W'(FRAME_W);
  localparam logic [TCNT_W-1:0] TCNT_FULL = TCNT_W'(ADDR_SIZE);

  typedef enum logic [2:0] {
    IDLE,
    CHK_CMD,
    WRITE,
    READ_ADD,
    READ_DATA,
    RD_WAIT,
    RD_SHIFT,
    FRAME_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [FRAME_W-1:0]   frame_q, frame_d;
  logic [BCNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [ADDR_SIZE-1:0] tx_sh_q, tx_sh_d;
  logic [TCNT_W-1:0]    tx_cnt_q, tx_cnt_d;
  logic                 rd_addr_seen_q, rd_addr_seen_d;
  logic                 miso_q, miso_d;
  logic [FRAME_W-1:0]   rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 cmd_ok;

`ifdef SPI_CMD_CHECK_EN
  logic cmd_err_q, cmd_err_d;

  always_comb begin
    cmd_ok = 1'b1;
    case (state_q)
      WRITE:     cmd_ok = ~frame_q[FRAME_W-1];
      READ_ADD:  cmd_ok = (frame_q[FRAME_W-1 -: 2] == 2'b10);
      READ_DATA: cmd_ok = (frame_q[FRAME_W-1 -: 2] == 2'b11);
      default:   cmd_ok = 1'b1;
    endcase
  end

  assign cmd_err = cmd_err_q;
`else
  assign cmd_ok  = 1'b1;
  assign cmd_err = 1'b0;
`endif

  always_comb begin
    state_d        = state_q;
    frame_d        = frame_q;
    bit_cnt_d      = bit_cnt_q;
    tx_sh_d        = tx_sh_q;
    tx_cnt_d       = tx_cnt_q;
    rd_addr_seen_d = rd_addr_seen_q;
    miso_d         = 1'b0;
    rx_data_d      = rx_data_q;
    rx_valid_d     = 1'b0;
`ifdef SPI_CMD_CHECK_EN
    cmd_err_d      = cmd_err_q;
`endif

    if (state_q != IDLE && bus.SS_n) begin
      // Deselect wins over any capture; only a fully shifted-out byte retires the read address.
      state_d   = IDLE;
      bit_cnt_d = '0;
      tx_cnt_d  = '0;
      if (state_q == RD_SHIFT && tx_cnt_q == TCNT_FULL) begin
        rd_addr_seen_d = 1'b0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          bit_cnt_d = '0;
          if (!bus.SS_n) begin
            state_d = CHK_CMD;
          end
        end

        CHK_CMD: begin
          frame_d   = {frame_q[FRAME_W-2:0], bus.MOSI};
          bit_cnt_d = BCNT_W'(1);
          if (!bus.MOSI) begin
            state_d = WRITE;
          end else if (rd_addr_seen_q) begin
            state_d = READ_DATA;
          end else begin
            state_d = READ_ADD;
          end
        end

        WRITE, READ_ADD, READ_DATA: begin
          if (bit_cnt_q != BCNT_FULL) begin
            frame_d   = {frame_q[FRAME_W-2:0], bus.MOSI};
            bit_cnt_d = bit_cnt_q + BCNT_W'(1);
          end else begin
            bit_cnt_d = '0;
            if (cmd_ok) begin
              rx_valid_d = 1'b1;
              rx_data_d  = frame_q;
              if (state_q == READ_ADD) begin
                rd_addr_seen_d = 1'b1;
              end
              state_d = (state_q == READ_DATA) ? RD_WAIT : FRAME_DONE;
            end else begin
`ifdef SPI_CMD_CHECK_EN
              cmd_err_d = 1'b1;
`endif
              state_d = FRAME_DONE;
            end
          end
        end

        RD_WAIT: begin
          if (bus.tx_valid) begin
            tx_sh_d  = {bus.tx_data[ADDR_SIZE-2:0], 1'b0};
            miso_d   = bus.tx_data[ADDR_SIZE-1];
            tx_cnt_d = TCNT_W'(1);
            state_d  = RD_SHIFT;
          end
        end

        RD_SHIFT: begin
          if (tx_cnt_q != TCNT_FULL) begin
            miso_d   = tx_sh_q[ADDR_SIZE-1];
            tx_sh_d  = {tx_sh_q[ADDR_SIZE-2:0], 1'b0};
            tx_cnt_d = tx_cnt_q + TCNT_W'(1);
          end else begin
            tx_cnt_d       = '0;
            rd_addr_seen_d = 1'b0;
            state_d        = FRAME_DONE;
          end
        end

        FRAME_DONE: begin
          state_d = FRAME_DONE;
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      frame_q        <= '0;
      bit_cnt_q      <= '0;
      tx_sh_q        <= '0;
      tx_cnt_q       <= '0;
      rd_addr_seen_q <= 1'b0;
      miso_q         <= 1'b0;
      rx_data_q      <= '0;
      rx_valid_q     <= 1'b0;
`ifdef SPI_CMD_CHECK_EN
      cmd_err_q      <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      frame_q        <= frame_d;
      bit_cnt_q      <= bit_cnt_d;
      tx_sh_q        <= tx_sh_d;
      tx_cnt_q       <= tx_cnt_d;
      rd_addr_seen_q <= rd_addr_seen_d;
      miso_q         <= miso_d;
      rx_data_q      <= rx_data_d;
      rx_valid_q     <= rx_valid_d;
`ifdef SPI_CMD_CHECK_EN
      cmd_err_q      <= cmd_err_d;
`endif
    end
  end

  assign bus.MISO     = miso_q;
  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;

endmodule
